lvds_sweep_seq: RTL and testbench
=================================

LVDS_SWEEP_SEQ -- requirements
Module: lvds_sweep_seq

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning), one per line:
- POR_CYC, 256, cycles POR is held asserted.
- SETTLE_CYC, 1024, settle cycles after each control-word change.
- MEAS_CYC, 65536, error-measurement window in cycles.
- CNT_W, 20, width of the internal dwell counter; every *_CYC SHALL be between 1 and 2^CNT_W.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning), one per line:
- CLK, in, 1, single clock; all logic is on its rising edge.
- RST, in, 1, synchronous active-high reset.
- START, in, 1, single-cycle request to begin a sweep.
- ABORT, in, 1, single-cycle request to abort a sweep.
- LAST_STEP, in, 6, final sweep index (inclusive); sampled on START.
- BASE_CTRL, in, 31, control bits not driven by the sweep.
- ERR_CNT, in, 64, running error count from the stimulus block.
- CTRL, out, 31, LVDS macro control word in the standard 31-bit layout (bit 30 SEL_RX_A … bit 0 POR).
- CLR, out, 1, one-cycle clear of the error/receive counters.
- BUSY, out, 1, high while a sweep is in progress.
- DONE, out, 1, high after a sweep completes normally.
- STEP, out, 6, current sweep index.
- RES_VALID, out, 1, one-cycle strobe marking a captured result.
- RES_IDX, out, 6, sweep index of the captured result.
- RES_ERR, out, 32, captured error count for that index.
- BEST_IDX, out, 6, index with the lowest error count so far.
- BEST_ERR, out, 32, lowest error count so far.

Function
REQ-003 The state machine SHALL have the states IDLE, POR, SETTLE, CLEAR, MEAS, CAPTURE and DONE.
REQ-004 In IDLE or DONE, a START with ABORT low SHALL latch LAST_STEP, set STEP=0, BEST_ERR=32'hFFFFFFFF and BEST_IDX=0, clear DONE, and enter POR on the next cycle.
REQ-005 POR SHALL last exactly POR_CYC cycles with CTRL[0]=1 and CTRL[26:25]=2'b11, then enter SETTLE.
REQ-006 SETTLE SHALL last exactly SETTLE_CYC cycles; it SHALL then enter CLEAR.
REQ-007 CLEAR SHALL last one cycle with CLR=1; it SHALL then enter MEAS.
REQ-008 MEAS SHALL last exactly MEAS_CYC cycles; it SHALL then enter CAPTURE.
REQ-009 CAPTURE SHALL last one cycle with RES_VALID=1, RES_IDX=STEP and RES_ERR=sat32(ERR_CNT).
REQ-010 sat32(x) SHALL be x[31:0] when x[63:32]==0, and 32'hFFFFFFFF otherwise.
REQ-011 In CAPTURE, if RES_ERR < BEST_ERR (strictly), BEST_ERR and BEST_IDX SHALL be updated on that edge; ties SHALL keep the earlier index.
REQ-012 After CAPTURE, if STEP==latched LAST_STEP the block SHALL enter DONE; otherwise it SHALL set STEP=STEP+1 (no wrap past 63) and enter SETTLE.
REQ-013 In every state except POR, CTRL SHALL equal BASE_CTRL with the following overrides:
- CTRL[0]=0.
- CTRL[26:25]=2'b00 in SETTLE, CLEAR, MEAS and CAPTURE.
- BASE_CTRL[26:25] passed through in IDLE and DONE.
REQ-014 While BUSY, the sweep fields SHALL be driven from STEP on both A and B sides:
- IDSET (bits 24:23 and 22:21) = STEP[5:4].
- DRV_STR (bits 18:17 and 16:15) = STEP[3:2].
- HYST (bits 20 and 19) = STEP[1].
- SR (bits 14 and 13) = STEP[0].
REQ-015 In IDLE and DONE, the sweep fields SHALL pass through from BASE_CTRL.
REQ-016 BUSY SHALL be 1 in states POR through CAPTURE, and DONE SHALL be 1 only in state DONE.
REQ-017 START SHALL be ignored while BUSY.
REQ-018 ABORT in any BUSY state SHALL force IDLE on the next cycle with no CLR and no RES_VALID pulse; BEST_* SHALL keep their values and DONE SHALL stay 0.
REQ-019 START and ABORT asserted together in IDLE or DONE SHALL leave the state unchanged.
REQ-020 LAST_STEP=0 SHALL perform exactly one measurement.
REQ-021 All outputs SHALL be registered, and each change in CTRL SHALL appear on the cycle the state is entered.

Reset
REQ-022 When RST=1 on a clock edge, the following SHALL hold on the next cycle, with RST taking priority over START and ABORT:
- State = IDLE.
- STEP=0, RES_IDX=0, RES_ERR=0, BEST_IDX=0.
- BEST_ERR=32'hFFFFFFFF.
- CLR=0, BUSY=0, DONE=0, RES_VALID=0.
- CTRL = BASE_CTRL with bit 0 cleared.
REQ-023 RST asserted mid-sweep SHALL behave identically to REQ-022, with no CLR and no RES_VALID pulse.

Verification
REQ-024 The bench SHALL cover the following directed scenarios with POR_CYC=4, SETTLE_CYC=3, MEAS_CYC=5:
- Full sweep: LAST_STEP=2, START -> CTRL[0]=1 for 4 cycles; then per step 3 SETTLE cycles, 1 CLR cycle, 5 MEAS cycles and 1 RES_VALID cycle; 3 RES_VALID pulses with RES_IDX 0,1,2; DONE=1 after the third.
- Best tracking: ERR_CNT = 7, 3, 3 at the three captures -> BEST_IDX=1, BEST_ERR=3.
- Saturation: ERR_CNT=64'h1_0000_0005 at capture -> RES_ERR=32'hFFFFFFFF.
- Sweep fields: STEP=6'b10_11_0_1 -> CTRL[24:21]=4'b1010, CTRL[18:15]=4'b1111, CTRL[20:19]=2'b00, CTRL[14:13]=2'b11, CTRL[26:25]=0.
- Abort: ABORT during MEAS of step 1 -> next cycle IDLE, BUSY=0, DONE=0, no RES_VALID; BEST_* unchanged.
- Reset/contention: RST asserted during CLEAR -> all outputs at REQ-022 values next cycle; START+ABORT together in IDLE -> stays IDLE.

Source files
------------

// File: rtl/lvds_sweep_seq.sv
// LVDS macro control-word sweep sequencer: steps the drive/termination fields
// through 0..LAST_STEP and records a saturated error count for each setting.
module lvds_sweep_seq #(
  parameter int POR_CYC    = 256,
  parameter int SETTLE_CYC = 1024,
  parameter int MEAS_CYC   = 65536,
  parameter int CNT_W      = 20
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        ABORT,
  input  logic [5:0]  LAST_STEP,
  input  logic [30:0] BASE_CTRL,
  input  logic [63:0] ERR_CNT,
  output logic [30:0] CTRL,
  output logic        CLR,
  output logic        BUSY,
  output logic        DONE,
  output logic [5:0]  STEP,
  output logic        RES_VALID,
  output logic [5:0]  RES_IDX,
  output logic [31:0] RES_ERR,
  output logic [5:0]  BEST_IDX,
  output logic [31:0] BEST_ERR
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_POR, ST_SETTLE, ST_CLEAR, ST_MEAS, ST_CAPTURE, ST_DONE
  } state_t;

  localparam logic [CNT_W-1:0] POR_LAST    = CNT_W'(POR_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] MEAS_LAST   = CNT_W'(MEAS_CYC - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [5:0]        step_reg, step_next;
  logic [5:0]        last_reg, last_next;
  logic [5:0]        best_idx_reg, best_idx_next;
  logic [31:0]       best_err_reg, best_err_next;
  logic [5:0]        res_idx_reg, res_idx_next;
  logic [31:0]       res_err_reg, res_err_next;
  logic [30:0]       ctrl_reg, ctrl_next;
  logic              clr_reg, busy_reg, done_reg, res_valid_reg;
  logic              busy_now;
  logic [31:0]       err_sat;

  // Control word for a given state/step; outputs are built from the next
  // state so every CTRL change lands on the cycle that state is entered.
  function automatic logic [30:0] ctrl_word(input state_t st, input logic [5:0] stp,
                                            input logic [30:0] base);
    logic [30:0] w;
    w    = base;
    w[0] = 1'b0;
    if (st != ST_IDLE && st != ST_DONE) begin
      w[24:23] = stp[5:4];
      w[22:21] = stp[5:4];
      w[20]    = stp[1];
      w[19]    = stp[1];
      w[18:17] = stp[3:2];
      w[16:15] = stp[3:2];
      w[14]    = stp[0];
      w[13]    = stp[0];
      w[26:25] = (st == ST_POR) ? 2'b11 : 2'b00;
      w[0]     = (st == ST_POR);
    end
    return w;
  endfunction

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg + 1'b1;
    step_next     = step_reg;
    last_next     = last_reg;
    best_idx_next = best_idx_reg;
    best_err_next = best_err_reg;
    res_idx_next  = res_idx_reg;
    res_err_next  = res_err_reg;
    busy_now      = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    err_sat       = (|ERR_CNT[63:32]) ? 32'hFFFF_FFFF : ERR_CNT[31:0];

    if (busy_now && ABORT) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          cnt_next = '0;
          if (START && !ABORT) begin
            state_next    = ST_POR;
            last_next     = LAST_STEP;
            step_next     = 6'd0;
            best_err_next = 32'hFFFF_FFFF;
            best_idx_next = 6'd0;
          end
        end
        ST_POR: begin
          if (cnt_reg == POR_LAST) begin
            state_next = ST_SETTLE;
            cnt_next   = '0;
          end
        end
        ST_SETTLE: begin
          if (cnt_reg == SETTLE_LAST) begin
            state_next = ST_CLEAR;
            cnt_next   = '0;
          end
        end
        ST_CLEAR: begin
          state_next = ST_MEAS;
          cnt_next   = '0;
        end
        ST_MEAS: begin
          if (cnt_reg == MEAS_LAST) begin
            state_next   = ST_CAPTURE;
            cnt_next     = '0;
            res_idx_next = step_reg;
            res_err_next = err_sat;
          end
        end
        ST_CAPTURE: begin
          cnt_next = '0;
          // Strict compare: a tie keeps the earlier index.
          if (res_err_reg < best_err_reg) begin
            best_err_next = res_err_reg;
            best_idx_next = res_idx_reg;
          end
          if (step_reg == last_reg) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_SETTLE;
            step_next  = (step_reg == 6'd63) ? step_reg : step_reg + 6'd1;
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      endcase
    end

    ctrl_next = ctrl_word(state_next, step_next, BASE_CTRL);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      step_reg      <= 6'd0;
      last_reg      <= 6'd0;
      best_idx_reg  <= 6'd0;
      best_err_reg  <= 32'hFFFF_FFFF;
      res_idx_reg   <= 6'd0;
      res_err_reg   <= 32'd0;
      ctrl_reg      <= {BASE_CTRL[30:1], 1'b0};
      clr_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      res_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      step_reg      <= step_next;
      last_reg      <= last_next;
      best_idx_reg  <= best_idx_next;
      best_err_reg  <= best_err_next;
      res_idx_reg   <= res_idx_next;
      res_err_reg   <= res_err_next;
      ctrl_reg      <= ctrl_next;
      clr_reg       <= (state_next == ST_CLEAR);
      busy_reg      <= (state_next != ST_IDLE) && (state_next != ST_DONE);
      done_reg      <= (state_next == ST_DONE);
      res_valid_reg <= (state_next == ST_CAPTURE);
    end
  end

  assign CTRL      = ctrl_reg;
  assign CLR       = clr_reg;
  assign BUSY      = busy_reg;
  assign DONE      = done_reg;
  assign STEP      = step_reg;
  assign RES_VALID = res_valid_reg;
  assign RES_IDX   = res_idx_reg;
  assign RES_ERR   = res_err_reg;
  assign BEST_IDX  = best_idx_reg;
  assign BEST_ERR  = best_err_reg;

endmodule

// File: tb/tb_lvds_sweep_seq.sv
// Bench for lvds_sweep_seq: directed sweeps with random data, checked cycle by
// cycle against a timeline computed from the phase lengths.
module tb_lvds_sweep_seq;

  localparam int POR = 4;
  localparam int SET = 3;
  localparam int MEA = 5;
  localparam int STEP_LEN = SET + 1 + MEA + 1;

  logic        clk, rst, start, abort;
  logic [5:0]  last_step;
  logic [30:0] base_ctrl;
  logic [63:0] err_cnt;
  logic [30:0] ctrl;
  logic        clr, busy, done, res_valid;
  logic [5:0]  step, res_idx, best_idx;
  logic [31:0] res_err, best_err;

  int checks = 0;
  int errors = 0;
  logic [63:0] errs [64];
  logic [5:0]  mbest_idx;
  logic [31:0] mbest_err;

  lvds_sweep_seq #(.POR_CYC(POR), .SETTLE_CYC(SET), .MEAS_CYC(MEA), .CNT_W(8)) dut (
    .CLK(clk), .RST(rst), .START(start), .ABORT(abort), .LAST_STEP(last_step),
    .BASE_CTRL(base_ctrl), .ERR_CNT(err_cnt), .CTRL(ctrl), .CLR(clr), .BUSY(busy),
    .DONE(done), .STEP(step), .RES_VALID(res_valid), .RES_IDX(res_idx),
    .RES_ERR(res_err), .BEST_IDX(best_idx), .BEST_ERR(best_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input logic [63:0] x);
    return (x > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : x[31:0];
  endfunction

  // phase: 0 idle, 1 por, 2 settle, 3 clear, 4 meas, 5 capture, 6 done
  function automatic logic [30:0] exp_ctrl(input int ph, input logic [5:0] s,
                                           input logic [30:0] b);
    logic [11:0] f;
    logic [30:0] r;
    f = {s[5:4], s[5:4], s[1], s[1], s[3:2], s[3:2], s[0], s[0]};
    r = b & ~31'd1;
    if (ph >= 1 && ph <= 5) begin
      r[24:13] = f;
      r[26:25] = (ph == 1) ? 2'b11 : 2'b00;
      r[0]     = (ph == 1);
    end
    return r;
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_clr"}, 64'(clr), 64'd0);
    chk({tag, "_rv"}, 64'(res_valid), 64'd0);
    chk({tag, "_step"}, 64'(step), 64'd0);
    chk({tag, "_residx"}, 64'(res_idx), 64'd0);
    chk({tag, "_reserr"}, 64'(res_err), 64'd0);
    chk({tag, "_bestidx"}, 64'(best_idx), 64'd0);
    chk({tag, "_besterr"}, 64'(best_err), 64'hFFFF_FFFF);
    chk({tag, "_ctrl"}, 64'(ctrl), 64'(base_ctrl & ~31'd1));
  endtask

  // stop_t>0: ABORT (or RST if use_rst) is driven during cycle stop_t.
  // poke_t>0: a stray START is driven during busy cycle poke_t.
  task automatic run_sweep(input logic [5:0] last, input int stop_t, input bit use_rst,
                           input int poke_t);
    int total, ph, s, o;
    total = POR + (int'(last) + 1) * STEP_LEN;
    @(negedge clk);
    last_step = last;
    start = 1'b1;
    abort = 1'b0;
    mbest_err = 32'hFFFF_FFFF;
    mbest_idx = 6'd0;
    for (int t = 1; t <= total + 3; t++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      rst   = 1'b0;
      if (t == 1) last_step = 6'($urandom);
      if (stop_t > 0 && t == stop_t + 1) begin
        if (use_rst) begin
          check_reset_values("rst_mid");
        end else begin
          chk("abort_busy", 64'(busy), 64'd0);
          chk("abort_done", 64'(done), 64'd0);
          chk("abort_clr", 64'(clr), 64'd0);
          chk("abort_rv", 64'(res_valid), 64'd0);
          chk("abort_ctrl", 64'(ctrl), 64'(exp_ctrl(0, 6'd0, base_ctrl)));
          chk("abort_bestidx", 64'(best_idx), 64'(mbest_idx));
          chk("abort_besterr", 64'(best_err), 64'(mbest_err));
        end
        break;
      end
      if (t <= POR) begin
        ph = 1;
        s  = 0;
      end else if (t <= total) begin
        o  = t - POR - 1;
        s  = o / STEP_LEN;
        o  = o % STEP_LEN;
        ph = (o < SET) ? 2 : (o == SET) ? 3 : (o <= SET + MEA) ? 4 : 5;
      end else begin
        ph = 6;
        s  = int'(last);
      end
      chk("busy", 64'(busy), 64'(ph >= 1 && ph <= 5));
      chk("done", 64'(done), 64'(ph == 6));
      chk("clr", 64'(clr), 64'(ph == 3));
      chk("res_valid", 64'(res_valid), 64'(ph == 5));
      chk("step", 64'(step), 64'(s));
      chk("ctrl", 64'(ctrl), 64'(exp_ctrl(ph, 6'(s), base_ctrl)));
      if (ph == 4 && s == 45) begin
        chk("fld_idset", 64'(ctrl[24:21]), 64'b1010);
        chk("fld_drv", 64'(ctrl[18:15]), 64'b1111);
        chk("fld_hyst", 64'(ctrl[20:19]), 64'b00);
        chk("fld_sr", 64'(ctrl[14:13]), 64'b11);
        chk("fld_term", 64'(ctrl[26:25]), 64'b00);
      end
      if (ph == 5) begin
        chk("res_idx", 64'(res_idx), 64'(s));
        chk("res_err", 64'(res_err), 64'(sat(errs[s])));
        if (sat(errs[s]) < mbest_err) begin
          mbest_err = sat(errs[s]);
          mbest_idx = 6'(s);
        end
      end
      if (ph == 6) begin
        chk("best_idx", 64'(best_idx), 64'(mbest_idx));
        chk("best_err", 64'(best_err), 64'(mbest_err));
      end
      // Error count for a step is held from its first settle cycle onward.
      if (ph >= 2 && ph <= 5) err_cnt = errs[s];
      else err_cnt = {$urandom, $urandom};
      if (t == total + 1) begin
        start = 1'b1;
        abort = 1'b1;
      end
      if (poke_t > 0 && t == poke_t) start = 1'b1;
      if (stop_t > 0 && t == stop_t) begin
        if (use_rst) rst = 1'b1;
        else abort = 1'b1;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    last_step = 6'd0;
    err_cnt = 64'd0;
    base_ctrl = 31'($urandom);
    repeat (3) @(negedge clk);
    check_reset_values("por_reset");
    rst = 1'b0;

    // IDLE passthrough and START+ABORT contention
    base_ctrl = 31'($urandom) | 31'd1;
    @(negedge clk);
    chk("idle_ctrl", 64'(ctrl), 64'(base_ctrl & ~31'd1));
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("contend_busy", 64'(busy), 64'd0);
      chk("contend_done", 64'(done), 64'd0);
    end

    // Full sweep with best tracking and a stray START during POR
    errs[0] = 64'd7;
    errs[1] = 64'd3;
    errs[2] = 64'd3;
    run_sweep(6'd2, 0, 1'b0, 2);

    // Single measurement with a saturating count
    errs[0] = 64'h1_0000_0005;
    run_sweep(6'd0, 0, 1'b0, 0);

    // Full 64-step random sweep
    base_ctrl = 31'($urandom);
    for (int i = 0; i < 64; i++)
      errs[i] = {(($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'd0),
                 32'($urandom_range(0, 1000))};
    run_sweep(6'd63, 0, 1'b0, 200);

    // Abort during MEAS of step 1
    for (int i = 0; i < 64; i++) errs[i] = 64'($urandom_range(0, 50));
    run_sweep(6'd3, POR + STEP_LEN + SET + 3, 1'b0, 0);

    // Reset during CLEAR of step 0
    base_ctrl = 31'($urandom);
    run_sweep(6'd2, POR + SET + 1, 1'b1, 0);

    // Recovery sweep with random length
    for (int i = 0; i < 64; i++) errs[i] = {32'd0, $urandom};
    run_sweep(6'($urandom_range(1, 5)), 0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
